// File: rtl/pmp_cfg_regs.sv
// RV32 PMP configuration/address CSR storage with WARL and lock enforcement.
// Serves one CSR request at a time and pulses flush_o after every legal write.
module pmp_cfg_regs #(
    parameter int unsigned NR_ENTRIES = 4,
    parameter int unsigned PMP_LEN    = 32
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic                           req_valid_i,
    output logic                           req_ready_o,
    input  logic                           req_we_i,
    input  logic [11:0]                    req_addr_i,
    input  logic [31:0]                    req_wdata_i,
    output logic                           rsp_valid_o,
    output logic [31:0]                    rsp_rdata_o,
    output logic                           rsp_err_o,
    output logic [15:0][7:0]               conf_o,
    output logic [15:0][PMP_LEN-1:0]       conf_addr_o,
    output logic                           flush_o
);

    localparam int unsigned NR_CSR_ENTRIES = 16;
    localparam logic [1:0]  A_TOR          = 2'b01;
    localparam logic [9:0]  CFG_BASE       = 10'h0E8;   // 0x3A0..0x3A3
    localparam logic [7:0]  ADDR_BASE      = 8'h3B;     // 0x3B0..0x3BF

    typedef enum logic [1:0] {
        IDLE,
        RESP,
        FLUSH
    } state_e;

    state_e                                  state_q;
    logic [NR_CSR_ENTRIES-1:0][7:0]          cfg_q, cfg_d;
    logic [NR_CSR_ENTRIES-1:0][PMP_LEN-1:0]  addr_q, addr_d;
    logic                                    ready_q;
    logic                                    rsp_valid_q;
    logic [31:0]                             rsp_rdata_q;
    logic                                    rsp_err_q;
    logic                                    flush_q;
    logic                                    wr_legal_q;

    logic                                    is_cfg;
    logic                                    is_addr;
    logic                                    accept;
    logic                                    err_d;
    logic                                    wr_legal_d;
    logic [31:0]                             rdata_d;
    logic [NR_CSR_ENTRIES:0]                 tor_lock;
    logic [NR_CSR_ENTRIES-1:0]               addr_lock;

    // Request decode
    always_comb begin
        is_cfg     = (req_addr_i[11:2] == CFG_BASE);
        is_addr    = (req_addr_i[11:4] == ADDR_BASE);
        accept     = ready_q && req_valid_i;
        err_d      = !(is_cfg || is_addr);
        wr_legal_d = req_we_i && !err_d;
    end

    // pmpaddr[i] is frozen by its own lock or by a locked TOR entry above it
    always_comb begin
        tor_lock                 = '0;
        addr_lock                = '0;
        tor_lock[NR_CSR_ENTRIES] = 1'b0;
        for (int unsigned e = 0; e < NR_CSR_ENTRIES; e++) begin
            tor_lock[e] = cfg_q[e][7] && (cfg_q[e][4:3] == A_TOR);
        end
        for (int unsigned e = 0; e < NR_CSR_ENTRIES; e++) begin
            addr_lock[e] = cfg_q[e][7] || tor_lock[e+1];
        end
    end

    // Next register contents for an accepted write
    always_comb begin
        logic [7:0] b;
        logic [3:0] ei;
        cfg_d  = cfg_q;
        addr_d = addr_q;
        b      = '0;
        ei     = '0;
        for (int unsigned e = 0; e < NR_CSR_ENTRIES; e++) begin
            ei = 4'(e);
            if (accept && req_we_i && is_cfg && (ei[3:2] == req_addr_i[1:0])
                && (e < NR_ENTRIES) && !cfg_q[e][7]) begin
                b      = req_wdata_i[{ei[1:0], 3'b000} +: 8];
                b[6:5] = 2'b00;
                if (b[1] && !b[0]) begin
                    b[1] = 1'b0;
                end
                cfg_d[e] = b;
            end
            if (accept && req_we_i && is_addr && (ei == req_addr_i[3:0])
                && (e < NR_ENTRIES) && !addr_lock[e]) begin
                addr_d[e] = req_wdata_i[PMP_LEN-1:0];
            end
        end
    end

    // Read data reflects state before this request's write
    always_comb begin
        rdata_d = '0;
        if (!req_we_i) begin
            if (is_cfg) begin
                rdata_d = cfg_q[{req_addr_i[1:0], 2'b00} +: 4];
            end else if (is_addr) begin
                rdata_d = 32'(addr_q[req_addr_i[3:0]]);
            end
        end
    end

    // Control FSM, registers and registered outputs
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q     <= IDLE;
            cfg_q       <= '0;
            addr_q      <= '0;
            ready_q     <= 1'b1;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            flush_q     <= 1'b0;
            wr_legal_q  <= 1'b0;
        end else begin
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            flush_q     <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (accept) begin
                        cfg_q       <= cfg_d;
                        addr_q      <= addr_d;
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= rdata_d;
                        rsp_err_q   <= err_d;
                        wr_legal_q  <= wr_legal_d;
                        ready_q     <= 1'b0;
                        state_q     <= RESP;
                    end
                end
                RESP: begin
                    if (wr_legal_q) begin
                        flush_q <= 1'b1;
                        state_q <= FLUSH;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                FLUSH: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
                default: begin
                    ready_q <= 1'b1;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign req_ready_o = ready_q;
    assign rsp_valid_o = rsp_valid_q;
    assign rsp_rdata_o = rsp_rdata_q;
    assign rsp_err_o   = rsp_err_q;
    assign flush_o     = flush_q;
    assign conf_o      = cfg_q;
    assign conf_addr_o = addr_q;

endmodule

// File: tb/tb_pmp_cfg_regs.sv
// Directed bench for pmp_cfg_regs: a 4-entry and a 16-entry instance share one
// request stream; expected responses are queued on accept and checked on rsp.
module tb_pmp_cfg_regs;

    logic        clk = 1'b0;
    logic        rst_i;
    logic        req_valid_i;
    logic        req_we_i;
    logic [11:0] req_addr_i;
    logic [31:0] req_wdata_i;

    logic              rdy_a, rdy_b, rv_a, rv_b, err_a, err_b, fl_a, fl_b;
    logic [31:0]       rd_a, rd_b;
    logic [15:0][7:0]  conf_a, conf_b;
    logic [15:0][31:0] addr_a, addr_b;

    typedef struct {
        logic [31:0] rd4;
        logic [31:0] rd16;
        logic        err;
        logic        flush;
    } exp_t;

    exp_t sb[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    pmp_cfg_regs #(.NR_ENTRIES(4), .PMP_LEN(32)) dut4 (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(rdy_a),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rv_a), .rsp_rdata_o(rd_a), .rsp_err_o(err_a),
        .conf_o(conf_a), .conf_addr_o(addr_a), .flush_o(fl_a)
    );

    pmp_cfg_regs #(.NR_ENTRIES(16), .PMP_LEN(32)) dut16 (
        .clk_i(clk), .rst_i(rst_i), .req_valid_i(req_valid_i), .req_ready_o(rdy_b),
        .req_we_i(req_we_i), .req_addr_i(req_addr_i), .req_wdata_i(req_wdata_i),
        .rsp_valid_o(rv_b), .rsp_rdata_o(rd_b), .rsp_err_o(err_b),
        .conf_o(conf_b), .conf_addr_o(addr_b), .flush_o(fl_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic xact(input logic we, input logic [11:0] a, input logic [31:0] wd,
                        input logic [31:0] e4, input logic [31:0] e16, input logic eerr);
        exp_t x;
        int   n;
        n = 0;
        while (!rdy_a && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk1("ready_before_req", rdy_a, 1'b1);
        req_valid_i = 1'b1;
        req_we_i    = we;
        req_addr_i  = a;
        req_wdata_i = wd;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        x.rd4   = e4;
        x.rd16  = e16;
        x.err   = eerr;
        x.flush = we && !eerr;
        sb.push_back(x);
        @(negedge clk);
        n = 1;
        while (!rv_a && n < 5) begin
            @(negedge clk);
            n++;
        end
        chk("rsp_latency", 32'(n), 32'd1);
        x = sb.pop_front();
        chk1("rsp_valid16", rv_b, 1'b1);
        chk("rdata4", rd_a, x.rd4);
        chk("rdata16", rd_b, x.rd16);
        chk1("err4", err_a, x.err);
        chk1("err16", err_b, x.err);
        chk1("flush_in_resp", fl_a | fl_b, 1'b0);
        chk1("ready_in_resp", rdy_a | rdy_b, 1'b0);
        @(negedge clk);
        chk1("rsp_one_cycle", rv_a | rv_b, 1'b0);
        chk1("flush4", fl_a, x.flush);
        chk1("flush16", fl_b, x.flush);
        chk1("ready_after_resp", rdy_a, !x.flush);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i       = 1'b1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        repeat (3) @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);

        chk1("rst_ready", rdy_a & rdy_b, 1'b1);
        chk1("rst_rsp_valid", rv_a | rv_b, 1'b0);
        chk1("rst_err", err_a | err_b, 1'b0);
        chk1("rst_flush", fl_a | fl_b, 1'b0);
        chk("rst_rdata", rd_a | rd_b, 32'h0);
        chk1("rst_conf", (|conf_a) | (|conf_b), 1'b0);
        chk1("rst_conf_addr", (|addr_a) | (|addr_b), 1'b0);

        xact(1'b0, 12'h3B0, 32'h0, 32'h0, 32'h0, 1'b0);

        xact(1'b1, 12'h3B1, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b0);
        chk("addr1_a", addr_a[1], 32'hFFFF_FFFF);
        chk("addr1_b", addr_b[1], 32'hFFFF_FFFF);
        xact(1'b1, 12'h3A0, 32'h0000_0F00, 32'h0, 32'h0, 1'b0);
        chk("conf1_tor_a", 32'(conf_a[1]), 32'h0F);
        chk("conf1_tor_b", 32'(conf_b[1]), 32'h0F);

        xact(1'b1, 12'h3A0, 32'h0000_8F00, 32'h0, 32'h0, 1'b0);
        chk("conf1_locked", 32'(conf_b[1]), 32'h8F);
        xact(1'b1, 12'h3B0, 32'h0000_1234, 32'h0, 32'h0, 1'b0);
        xact(1'b1, 12'h3B1, 32'h0000_5678, 32'h0, 32'h0, 1'b0);
        chk("addr0_tor_blocked_a", addr_a[0], 32'h0);
        chk("addr0_tor_blocked_b", addr_b[0], 32'h0);
        chk("addr1_lock_blocked", addr_b[1], 32'hFFFF_FFFF);
        xact(1'b1, 12'h3A0, 32'h0, 32'h0, 32'h0, 1'b0);
        chk("conf1_keeps_lock_a", 32'(conf_a[1]), 32'h8F);
        chk("conf1_keeps_lock_b", 32'(conf_b[1]), 32'h8F);

        xact(1'b1, 12'h3A0, 32'h0000_0063, 32'h0, 32'h0, 1'b0);
        chk("conf0_resv_cleared", 32'(conf_b[0]), 32'h03);
        chk("conf1_still_locked", 32'(conf_b[1]), 32'h8F);

        xact(1'b1, 12'h3A2, 32'h0000_00E2, 32'h0, 32'h0, 1'b0);
        chk("conf8_nr4", 32'(conf_a[8]), 32'h00);
        chk("conf8_nr16", 32'(conf_b[8]), 32'h80);
        xact(1'b0, 12'h3A2, 32'h0, 32'h0, 32'h0000_0080, 1'b0);
        xact(1'b0, 12'h3A0, 32'h0, 32'h0000_8F03, 32'h0000_8F03, 1'b0);
        xact(1'b0, 12'h3B1, 32'h0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);

        xact(1'b1, 12'h3B4, 32'h0000_CAFE, 32'h0, 32'h0, 1'b0);
        xact(1'b0, 12'h3B4, 32'h0, 32'h0, 32'h0000_CAFE, 1'b0);
        xact(1'b1, 12'h3BF, 32'h0000_0001, 32'h0, 32'h0, 1'b0);
        xact(1'b0, 12'h3BF, 32'h0, 32'h0, 32'h0000_0001, 1'b0);

        xact(1'b0, 12'h3C0, 32'h0, 32'h0, 32'h0, 1'b1);
        xact(1'b0, 12'h3A4, 32'h0, 32'h0, 32'h0, 1'b1);
        xact(1'b1, 12'h7A0, 32'hFFFF_FFFF, 32'h0, 32'h0, 1'b1);
        chk("err_no_change_conf0", 32'(conf_b[0]), 32'h03);
        chk("err_no_change_conf1", 32'(conf_b[1]), 32'h8F);
        chk("err_no_change_addr1", addr_b[1], 32'hFFFF_FFFF);

        // Reset during the RESP cycle of an accepted write
        chk1("ready_before_rst_req", rdy_a, 1'b1);
        req_valid_i = 1'b1;
        req_we_i    = 1'b1;
        req_addr_i  = 12'h3B2;
        req_wdata_i = 32'h0000_ABCD;
        @(posedge clk);
        #1;
        req_valid_i = 1'b0;
        req_we_i    = 1'b0;
        req_addr_i  = '0;
        req_wdata_i = '0;
        rst_i       = 1'b1;
        chk("addr2_written", addr_b[2], 32'h0000_ABCD);
        @(posedge clk);
        #1 rst_i = 1'b0;
        @(negedge clk);
        chk1("rst_resp_dropped", rv_a | rv_b, 1'b0);
        chk1("rst_no_flush", fl_a | fl_b, 1'b0);
        chk("rst_addr2_a", addr_a[2], 32'h0);
        chk("rst_addr2_b", addr_b[2], 32'h0);
        chk1("rst_ready_back", rdy_a & rdy_b, 1'b1);
        chk("rst_lock_cleared", 32'(conf_b[1]), 32'h0);
        @(negedge clk);
        chk1("rst_no_late_flush", fl_a | fl_b, 1'b0);

        chk("scoreboard_empty", 32'(sb.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pmp_cfg_regs.md
# pmp_cfg_regs

Holds the RV32 PMP configuration and address CSRs (`pmpcfg0..3`, `pmpaddr0..15`) and drives the per-entry `conf_i` / `conf_addr_i` inputs of the combinational `pmp` checker, which is its direct downstream consumer. Accesses arrive from the CSR file over a valid/ready request port. The block enforces WARL and lock rules and returns a registered response. After every legal write it pulses a flush, so that downstream translation and PMP caches drop stale permissions.

## Interface
Parameters:
- `NR_ENTRIES`, 4: implemented entries, 0..16. Entries at index `NR_ENTRIES` and above are hard-wired to zero.
- `PMP_LEN`, 32: `pmpaddr` width, holding physical address bits [PMP_LEN+1:2].

Ports:
- `clk_i`  in  1  clock, rising edge.
- `rst_i`  in  1  reset, synchronous, active-high.
- `req_valid_i`  in  1  CSR access request.
- `req_ready_o`  out  1  block can accept a request.
- `req_we_i`  in  1  1 = write, 0 = read.
- `req_addr_i`  in  12  CSR address.
- `req_wdata_i`  in  32  write data. Set/clear has already been resolved by the CSR file.
- `rsp_valid_o`  out  1  response strobe, one cycle. There is no back-pressure.
- `rsp_rdata_o`  out  32  read data. It is 0 for writes and errors.
- `rsp_err_o`  out  1  illegal CSR address.
- `conf_o`  out  16×8  `riscv::pmpcfg_t` per entry. Bit [7] L, bits [6:5] reserved (always 0), bits [4:3] A, bit [2] X, bit [1] W, bit [0] R.
- `conf_addr_o`  out  16×PMP_LEN  `pmpaddr` per entry.
- `flush_o`  out  1  one-cycle pulse after a legal write.

## Operation
- Address map:
  - `pmpcfg0..3` = 0x3A0..0x3A3. Byte k of `pmpcfgN` is entry 4N+k.
  - `pmpaddr0..15` = 0x3B0..0x3BF.
  - Any other address gives `rsp_err_o`=1, with no state change and no flush.
- Unimplemented entries (index ≥ NR_ENTRIES): they read as 0 and writes to them are dropped. This is legal, not an error.
- `pmpcfg` write rules, applied per byte:
  - A byte whose stored L=1 is not modified.
  - Bits [6:5] are forced to 0.
  - Written W=1 with R=0 is stored as W=0 (WARL), with the other bits kept as written.
  - All A encodings (OFF, TOR, NA4, NAPOT) are stored as written.
- `pmpaddr[i]` write rule: the write is ignored if `conf[i].L`=1, or if `conf[i+1].L`=1 and `conf[i+1].A`=TOR (this second condition applies for i<15). Otherwise bits [PMP_LEN-1:0] are stored and upper bits are discarded.
- Reads:
  - `pmpcfg` returns the 4 stored bytes.
  - `pmpaddr` returns the stored value zero-extended to 32 bits.
- Lock bits are cleared only by reset.
- FSM:
  - IDLE: `req_ready_o`=1. On `req_valid_i` the request is captured; writes update the registers at this edge. Next state is RESP.
  - RESP: `rsp_valid_o`=1 with data and error. Next state is FLUSH for a legal write, otherwise IDLE.
  - FLUSH: `flush_o`=1, `req_ready_o`=0. Next state is IDLE.
- A flush happens on any legal-address write, even if lock rules suppressed every bit.

## Timing
- Reset values:
  - All `conf_o` and `conf_addr_o` = 0.
  - `rsp_valid_o`=0, `rsp_rdata_o`=0, `rsp_err_o`=0, `flush_o`=0.
  - `req_ready_o`=1 (state IDLE).
- The accept edge is the rising edge with `req_valid_i && req_ready_o`.
- Write latency: new register values appear on `conf_o` / `conf_addr_o` in the cycle after the accept edge, which is the same cycle as `rsp_valid_o`.
- Read latency: `rsp_valid_o` and `rsp_rdata_o` appear in the cycle after the accept edge. The read returns the value as it was before any write in that same cycle (only one request is possible per accept edge).
- `flush_o` fires 2 cycles after the accept edge.
- Throughput:
  - Reads and errors: one accept per 2 cycles.
  - Legal writes: one accept per 3 cycles.
- `req_*` inputs are sampled only on the accept edge. They are don't-care while `req_ready_o`=0.
- Reset asserted in RESP or FLUSH: the response or flush is dropped and the state returns to IDLE with reset values on the next edge. A write that was already accepted is lost, because the registers are reset.
- Outputs are driven by registers only. There is no combinational path from `req_*` to any output.

## Test plan
- Reset, then read 0x3B0 → `req_ready_o`=1 after reset; response after 1 cycle with `rsp_rdata_o`=0, `rsp_err_o`=0, `flush_o` never asserted.
- Write 0x3B1=0xFFFF_FFFF, then write 0x3A0=0x0000_0F00 (entry 1: TOR, RWX) → `conf_addr_o[1]`=0xFFFF_FFFF, `conf_o[1]`=0x0F. `flush_o` pulses 2 cycles after each accept, and `req_ready_o` is low during each FLUSH cycle.
- Write 0x3A0=0x0000_8F00 (entry 1 locked, TOR), then write 0x3B0=0x1234 and 0x3B1=0x5678 → both `pmpaddr` values unchanged (entry 0 is blocked by the TOR lock on entry 1), and a flush still occurs for each write. A following write 0x3A0=0 leaves `conf_o[1]`=0x8F.
- Write 0x3A2=0x0000_00E2 (entry 8: reserved bits set, W=1, R=0, with NR_ENTRIES=16) → `conf_o[8]`=0x80 and read-back returns 0x0000_0080. With NR_ENTRIES=4, the same write leaves `conf_o[8]`=0, reads back 0, and `rsp_err_o`=0.
- Read 0x3C0 and write 0x7A0 → `rsp_err_o`=1, `rsp_rdata_o`=0, no flush, no register change, and the next request can be accepted 2 cycles after the previous accept.
- Assert `rst_i` in the RESP cycle of a write to 0x3B2 → no `rsp_valid_o` and no `flush_o`; `conf_addr_o[2]`=0 and `req_ready_o`=1 on the following cycle.
